// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback requesters, the CPU stall control and the register file.
// Handshake: a requester transfers on a rising edge where its valid and ready are both 1;
// ready is driven whether or not valid is asserted, and valid never waits on ready.
interface regfile_wb_arbiter_if;
  logic        hold;
  logic        a_valid;
  logic [2:0]  a_id;
  logic [15:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [2:0]  b_id;
  logic [15:0] b_data;
  logic        b_ready;
  logic        reg_we;
  logic [2:0]  reg_w_id;
  logic [15:0] reg_wdata;
  logic [7:0]  pend_mask;
  logic        conflict;
  logic        stage_state;

  modport slave (
    input  hold, a_valid, a_id, a_data, b_valid, b_id, b_data,
    output a_ready, b_ready, reg_we, reg_w_id, reg_wdata, pend_mask, conflict, stage_state
  );

  modport master (
    output hold, a_valid, a_id, a_data, b_valid, b_id, b_data,
    input  a_ready, b_ready, reg_we, reg_w_id, reg_wdata, pend_mask, conflict, stage_state
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for two register-file writeback requesters feeding a one-entry
// output stage that is stalled by the CPU hold signal.
module regfile_wb_arbiter (
  input logic             clk,
  input logic             rst,
  regfile_wb_arbiter_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, LOADED = 1'b1} stage_e;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  stage_e      state, state_nx;
  logic [2:0]  stg_id, stg_id_nx;
  logic [15:0] stg_d, stg_d_nx;
  logic        last, last_nx;
  logic        conflict_q, conflict_nx;
  logic        grant_a, grant_b;

  // A requester may go when the other is idle or it is the other's turn to yield.
  assign bus.a_ready = !bus.hold && (!bus.b_valid || last == LAST_B);
  assign bus.b_ready = !bus.hold && (!bus.a_valid || last == LAST_A);
  assign grant_a     = bus.a_valid && bus.a_ready;
  assign grant_b     = bus.b_valid && bus.b_ready;

  always_comb begin
    state_nx    = state;
    stg_id_nx   = stg_id;
    stg_d_nx    = stg_d;
    last_nx     = last;
    conflict_nx = bus.a_valid && bus.b_valid && (bus.a_id == bus.b_id) && !bus.hold;
    if (!bus.hold) begin
      state_nx = (grant_a || grant_b) ? LOADED : EMPTY;
      if (grant_a) begin
        stg_id_nx = bus.a_id;
        stg_d_nx  = bus.a_data;
        last_nx   = LAST_A;
      end else if (grant_b) begin
        stg_id_nx = bus.b_id;
        stg_d_nx  = bus.b_data;
        last_nx   = LAST_B;
      end
    end
  end

  // Reset leaves LAST pointing at B so that A wins the first contended cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      stg_id     <= 3'd0;
      stg_d      <= 16'd0;
      last       <= LAST_B;
      conflict_q <= 1'b0;
    end else begin
      state      <= state_nx;
      stg_id     <= stg_id_nx;
      stg_d      <= stg_d_nx;
      last       <= last_nx;
      conflict_q <= conflict_nx;
    end
  end

  assign bus.reg_we      = (state == LOADED) && !bus.hold;
  assign bus.reg_w_id    = stg_id;
  assign bus.reg_wdata   = stg_d;
  assign bus.pend_mask   = (state == LOADED) ? (8'h01 << stg_id) : 8'h00;
  assign bus.conflict    = conflict_q;
  assign bus.stage_state = state;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-cycle vector table with hand-derived outputs, a
// write scoreboard, and a randomized hold-stall sequence.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst;
  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        rst;
    logic        hold;
    logic        av;
    logic [2:0]  aid;
    logic [15:0] ad;
    logic        bv;
    logic [2:0]  bid;
    logic [15:0] bd;
    logic        e_ar;
    logic        e_br;
    logic        e_we;
    logic [2:0]  e_wid;
    logic [15:0] e_wd;
    logic [7:0]  e_pm;
    logic        e_cf;
  } vec_t;

  vec_t        vecs[$];
  logic [18:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int row, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic h,
                     input logic av, input logic [2:0] aid, input logic [15:0] ad,
                     input logic bv, input logic [2:0] bid, input logic [15:0] bd,
                     input logic ear, input logic ebr, input logic ewe,
                     input logic [2:0] ewid, input logic [15:0] ewd,
                     input logic [7:0] epm, input logic ecf);
    vec_t v;
    v.rst = r; v.hold = h; v.av = av; v.aid = aid; v.ad = ad;
    v.bv = bv; v.bid = bid; v.bd = bd; v.e_ar = ear; v.e_br = ebr;
    v.e_we = ewe; v.e_wid = ewid; v.e_wd = ewd; v.e_pm = epm; v.e_cf = ecf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic h,
                       input logic av, input logic [2:0] aid, input logic [15:0] ad,
                       input logic bv, input logic [2:0] bid, input logic [15:0] bd);
    rst = r; bus.hold = h;
    bus.a_valid = av; bus.a_id = aid; bus.a_data = ad;
    bus.b_valid = bv; bus.b_id = bid; bus.b_data = bd;
  endtask

  // scoreboard: every reg_we pulse must retire the oldest granted write
  task automatic sb_pop(input int row);
    if (bus.reg_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", row, {bus.reg_w_id, bus.reg_wdata}, 19'h7ffff);
      end else begin
        check("wb_write", row, {bus.reg_w_id, bus.reg_wdata}, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    vec_t       v;
    logic [2:0] rid;
    logic [15:0] rd;
    logic [7:0] rm;
    int         n;

    drive(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    repeat (2) @(negedge clk);

    //   rst hold av aid ad       bv bid bd       ar br we wid wd        pm     cf
    add(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 0, 16'd0,    8'h00, 0);
    add(0, 0, 1, 3, 16'd123,  0, 0, 16'h0000, 1, 0, 0, 0, 16'd0,    8'h00, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 3, 16'd123,  8'h08, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 3, 16'd123,  8'h00, 0);
    add(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 3, 16'd123,  8'h00, 0);
    add(0, 0, 1, 1, 16'h1111, 1, 2, 16'h2220, 1, 0, 0, 0, 16'd0,    8'h00, 0);
    add(0, 0, 1, 1, 16'h1112, 1, 2, 16'h2221, 0, 1, 1, 1, 16'h1111, 8'h02, 0);
    add(0, 0, 1, 1, 16'h1113, 1, 2, 16'h2222, 1, 0, 1, 2, 16'h2221, 8'h04, 0);
    add(0, 0, 1, 1, 16'h1114, 1, 2, 16'h2223, 0, 1, 1, 1, 16'h1113, 8'h02, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 2, 16'h2223, 8'h04, 0);
    add(0, 0, 1, 5, 16'd10,   1, 5, 16'd20,   1, 0, 0, 2, 16'h2223, 8'h00, 0);
    add(0, 0, 0, 0, 16'h0000, 1, 5, 16'd20,   0, 1, 1, 5, 16'd10,   8'h20, 1);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 5, 16'd20,   8'h20, 0);
    add(0, 0, 1, 7, 16'h0777, 0, 0, 16'h0000, 1, 0, 0, 5, 16'd20,   8'h00, 0);
    add(0, 1, 1, 6, 16'h0666, 1, 6, 16'h0444, 0, 0, 0, 7, 16'h0777, 8'h80, 0);
    add(0, 1, 1, 6, 16'h0666, 1, 6, 16'h0444, 0, 0, 0, 7, 16'h0777, 8'h80, 0);
    add(0, 1, 1, 6, 16'h0666, 1, 6, 16'h0444, 0, 0, 0, 7, 16'h0777, 8'h80, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 7, 16'h0777, 8'h80, 0);
    add(0, 0, 1, 4, 16'hAAAA, 0, 0, 16'h0000, 1, 1, 0, 7, 16'h0777, 8'h00, 0);
    add(0, 0, 1, 4, 16'hBBBB, 0, 0, 16'h0000, 1, 1, 1, 4, 16'hAAAA, 8'h10, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 4, 16'hBBBB, 8'h10, 0);
    add(0, 0, 0, 0, 16'h0000, 1, 2, 16'h0BBB, 0, 1, 0, 4, 16'hBBBB, 8'h00, 0);
    add(0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 2, 16'h0BBB, 8'h04, 0);
    add(1, 1, 1, 1, 16'h5555, 0, 0, 16'h0000, 0, 0, 0, 2, 16'h0BBB, 8'h04, 0);
    add(0, 0, 1, 3, 16'h3333, 1, 6, 16'h6666, 1, 0, 0, 0, 16'd0,    8'h00, 0);
    add(0, 0, 0, 0, 16'h0000, 1, 6, 16'h6666, 0, 1, 1, 3, 16'h3333, 8'h08, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 6, 16'h6666, 8'h40, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 6, 16'h6666, 8'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.rst, v.hold, v.av, v.aid, v.ad, v.bv, v.bid, v.bd);
      #1;
      check("a_ready",   i, {18'd0, bus.a_ready},   {18'd0, v.e_ar});
      check("b_ready",   i, {18'd0, bus.b_ready},   {18'd0, v.e_br});
      check("reg_we",    i, {18'd0, bus.reg_we},    {18'd0, v.e_we});
      check("reg_w_id",  i, {16'd0, bus.reg_w_id},  {16'd0, v.e_wid});
      check("reg_wdata", i, {3'd0, bus.reg_wdata},  {3'd0, v.e_wd});
      check("pend_mask", i, {11'd0, bus.pend_mask}, {11'd0, v.e_pm});
      check("conflict",  i, {18'd0, bus.conflict},  {18'd0, v.e_cf});
      if (!v.rst) sb_pop(i);
      if (!v.rst && v.av && v.e_ar) exp_q.push_back({v.aid, v.ad});
      if (!v.rst && v.bv && v.e_br) exp_q.push_back({v.bid, v.bd});
      if (v.rst) exp_q.delete();
    end

    // stage loaded then stalled for a random number of cycles; write must survive
    for (int k = 0; k < 4; k++) begin
      rid = 3'($urandom_range(0, 7));
      rd  = 16'($urandom_range(0, 65535));
      rm  = 8'h01 << rid;
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, rid, rd, 1'b0, 3'd0, 16'd0);
      #1;
      check("hs_a_ready", 100 + k, {18'd0, bus.a_ready}, 19'd1);
      exp_q.push_back({rid, rd});
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b1, rid, 16'hFFFF);
        #1;
        check("hs_we_held",  100 + k, {18'd0, bus.reg_we},    19'd0);
        check("hs_b_ready",  100 + k, {18'd0, bus.b_ready},   19'd0);
        check("hs_pend",     100 + k, {11'd0, bus.pend_mask}, {11'd0, rm});
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
      #1;
      check("hs_we_release", 100 + k, {18'd0, bus.reg_we}, 19'd1);
      sb_pop(100 + k);
      @(negedge clk);
      #1;
      check("hs_we_idle", 100 + k, {18'd0, bus.reg_we}, 19'd0);
    end

    check("queue_empty", 999, 19'(exp_q.size()), 19'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 CLK  in  1  rising-edge clock, same clock as the register file.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 HOLD  in  1  writeback stall from the CPU controller.
REQ-005 A_VALID  in  1  requester A (ALU writeback) has a write pending.
REQ-006 A_ID  in  3  destination register for A.
REQ-007 A_DATA  in  16  write data for A.
REQ-008 A_READY  out  1  A is granted this cycle.
REQ-009 B_VALID, B_ID, B_DATA, B_READY SHALL mirror REQ-005..REQ-008 for requester B (load writeback), with the same widths.
REQ-010 Reg_WE  out  1  register-file write enable.
REQ-011 REG_W_ID  out  3  register-file write index.
REQ-012 Reg_WData  out  16  register-file write data.
REQ-013 PEND_MASK  out  8  one-hot mask of the register held in the output stage.
REQ-014 CONFLICT  out  1  registered pulse: both requesters targeted the same ID in one cycle.

Function
REQ-015 The block SHALL contain a one-entry output stage: STG_V, STG_ID[2:0] and STG_D[15:0].
REQ-016 Stage states SHALL be EMPTY (STG_V=0) and LOADED (STG_V=1).
REQ-017 A transfer SHALL occur on a requester when VALID and READY are both 1 at a rising CLK edge.
REQ-018 LAST (1 bit: 0=A, 1=B) SHALL record the requester most recently granted.
REQ-019 A_READY SHALL be !HOLD && (!B_VALID || LAST==B).
REQ-020 B_READY SHALL be !HOLD && (!A_VALID || LAST==A).
REQ-021 READY SHALL be driven regardless of the requester's own VALID.
REQ-022 At most one grant SHALL occur per cycle.
REQ-023 When both requesters are valid, the grant SHALL alternate (round-robin).
REQ-024 A single valid requester SHALL be granted every cycle that HOLD=0.
REQ-025 LAST SHALL update only on a cycle in which a transfer occurs.
REQ-026 With HOLD=0, each edge SHALL load STG_V=grant_any.
REQ-027 On that same edge, STG_ID and STG_D SHALL load from the granted requester.
REQ-028 With HOLD=0 and no grant, the stage SHALL go EMPTY and STG_ID/STG_D SHALL keep their values.
REQ-029 With HOLD=1, STG_V, STG_ID, STG_D and LAST SHALL all be retained.
REQ-030 Reg_WE SHALL be STG_V && !HOLD (combinational).
REQ-031 REG_W_ID SHALL be STG_ID and Reg_WData SHALL be STG_D.
REQ-032 Latency: a transfer at edge N SHALL give Reg_WE=1 during cycle N..N+1.
REQ-033 The register file SHALL be written at edge N+1 if HOLD=0 in that cycle.
REQ-034 If HOLD is raised while the stage is LOADED, the write SHALL be delayed, not lost.
REQ-035 PEND_MASK SHALL be (1<<STG_ID) when STG_V=1 and 8'h00 otherwise, independent of HOLD.
REQ-036 CONFLICT SHALL register A_VALID && B_VALID && A_ID==B_ID && !HOLD.
REQ-037 CONFLICT SHALL be high for exactly the cycle after the collision.
REQ-038 On a same-ID collision, the granted write SHALL be applied first and the other on a later cycle (last writer wins).
REQ-039 The block SHALL not interpret data; widths SHALL pass through unmodified (16-bit, no sign or extension).
REQ-040 Back-to-back writes to the same ID on consecutive cycles SHALL each be issued in order.

Reset
REQ-041 With RST=1 at an edge: STG_V=0, STG_ID=0, STG_D=0, LAST=1 (B), CONFLICT=0.
REQ-042 After reset, Reg_WE=0, REG_W_ID=0, Reg_WData=0 and PEND_MASK=8'h00.
REQ-043 After reset, A SHALL win the first contended cycle.
REQ-044 RST SHALL override HOLD and any transfer in the same cycle; a staged write SHALL be discarded.
REQ-045 During RST=1, READY outputs SHALL still follow REQ-019/REQ-020; any transfer is discarded.

Verification
REQ-046 Reset, then A_VALID=1, A_ID=3, A_DATA=16'd123 for one cycle -> next cycle Reg_WE=1, REG_W_ID=3, Reg_WData=123, PEND_MASK=8'h08.
REQ-047 A and B valid for 4 cycles (A_ID=1, B_ID=2) -> grant order A,B,A,B and Reg_WE=1 for 4 consecutive cycles.
REQ-048 A_ID=B_ID=5 with A_DATA=10 and B_DATA=20 -> CONFLICT=1 for one cycle; writes to 5 issue as 10 then 20.
REQ-049 Stage LOADED (ID 7), HOLD=1 for 3 cycles -> Reg_WE=0, both READY=0, PEND_MASK=8'h80 held; HOLD=0 -> Reg_WE=1, ID 7.
REQ-050 RST asserted while the stage is LOADED and HOLD=1 -> next cycle STG_V=0, Reg_WE=0, PEND_MASK=0.
REQ-050 (cont.) After that reset, the first contention SHALL grant A.
